hps_pio_link: RTL

HPS-facing link layer between the 32-bit lightweight-bridge PIO pair and the FPGA processing core. It runs a 4-phase req/ack handshake with HPS software over `pio_in`/`pio_out`. Received bytes are buffered into an RX FIFO, which the core drains over a valid/ready stream. The core's result bytes are buffered into a TX FIFO and returned to the HPS one byte per handshake. The block also decodes the frame-start bit into a single-cycle pulse for the core.

---
 rtl/hps_pio_link.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/hps_pio_link.sv
`default_nettype none
// ============================================================================
// Module   : hps_pio_link
// Purpose  : Link layer between the HPS lightweight-bridge PIO pair and the
//            FPGA processing core. Runs a 4-phase req/ack handshake with HPS
//            software, buffers written bytes in an RX FIFO drained by the
//            core, and returns core result bytes from a TX FIFO to the HPS.
// Ports    : clk, reset       - system clock, async active-high reset
//            pio_in[31:0]     - HPS word: [31] req, [30] start, [29] dir,
//                               [7:0] write data
//            pio_out[31:0]    - status: [31] ack, [30] tx_avail,
//                               [29] rx_full, [28] protocol_err,
//                               [7:0] read data
//            rx_data/rx_valid/rx_ready - RX stream towards the core
//            tx_data/tx_valid/tx_ready - TX stream from the core
//            frame_start      - one-cycle pulse on an accepted start
//            link_state[2:0]  - debug state code
// Revision : 1.0 - initial release
// ============================================================================
module hps_pio_link #(
    parameter int SYNC_STAGES = 3,
    parameter int RX_DEPTH    = 16,
    parameter int TX_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pio_in,
    output logic [31:0] pio_out,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        frame_start,
    output logic [2:0]  link_state
);

    localparam int c_RX_AW = $clog2(RX_DEPTH);
    localparam int c_TX_AW = $clog2(TX_DEPTH);
    localparam logic [c_RX_AW:0] c_RX_PTR_ONE = {{c_RX_AW{1'b0}}, 1'b1};
    localparam logic [c_TX_AW:0] c_TX_PTR_ONE = {{c_TX_AW{1'b0}}, 1'b1};

    localparam logic [2:0] c_ST_IDLE  = 3'b000;
    localparam logic [2:0] c_ST_WRITE = 3'b001;
    localparam logic [2:0] c_ST_READ  = 3'b010;
    localparam logic [2:0] c_ST_ACK   = 3'b100;

    // ------------------------------------------------------------------
    // Synchronizers and rising-edge detection for req and start
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_start_sync;
    logic                   r_req_prev;
    logic                   r_start_prev;
    logic                   w_req_lvl;
    logic                   w_start_lvl;
    logic                   w_req_rise;
    logic                   w_start_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req_sync   <= '0;
            r_start_sync <= '0;
            r_req_prev   <= 1'b0;
            r_start_prev <= 1'b0;
        end else begin
            r_req_sync   <= {r_req_sync[SYNC_STAGES-2:0], pio_in[31]};
            r_start_sync <= {r_start_sync[SYNC_STAGES-2:0], pio_in[30]};
            r_req_prev   <= w_req_lvl;
            r_start_prev <= w_start_lvl;
        end
    end

    assign w_req_lvl    = r_req_sync[SYNC_STAGES-1];
    assign w_start_lvl  = r_start_sync[SYNC_STAGES-1];
    assign w_req_rise   = w_req_lvl & ~r_req_prev;
    assign w_start_rise = w_start_lvl & ~r_start_prev;

    // ------------------------------------------------------------------
    // Link state machine
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [7:0] r_hold;
    logic [7:0] r_rd_reg;
    logic       r_proto_err;
    logic       r_frame_start;
    logic       w_flush;

    logic       w_rx_full;
    logic       w_rx_empty;
    logic       w_tx_full;
    logic       w_tx_empty;
    logic [7:0] w_tx_head;

    // An accepted start is only one seen while idle; it empties both FIFOs.
    assign w_flush = (r_state == c_ST_IDLE) && w_start_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_hold        <= 8'h00;
            r_rd_reg      <= 8'h00;
            r_proto_err   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // Start wins over a coincident req edge; that req edge is lost.
                    if (w_start_rise) begin
                        r_proto_err   <= 1'b0;
                        r_frame_start <= 1'b1;
                    end else if (w_req_rise) begin
                        r_hold  <= pio_in[7:0];
                        r_state <= pio_in[29] ? c_ST_READ : c_ST_WRITE;
                    end
                end
                c_ST_WRITE: begin
                    if (!w_rx_full) begin
                        r_state <= c_ST_ACK;
                    end
                end
                c_ST_READ: begin
                    if (!w_tx_empty) begin
                        r_rd_reg <= w_tx_head;
                        r_state  <= c_ST_ACK;
                    end
                end
                c_ST_ACK: begin
                    if (!w_req_lvl) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
            // A start arriving mid-handshake is a software error; remember it.
            if (w_start_rise && (r_state != c_ST_IDLE)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO: link pushes the held byte, core pops
    // ------------------------------------------------------------------
    logic [7:0]       r_rx_mem [RX_DEPTH];
    logic [c_RX_AW:0] r_rx_wr;
    logic [c_RX_AW:0] r_rx_rd;
    logic             w_rx_push;
    logic             w_rx_pop;

    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[c_RX_AW] != r_rx_rd[c_RX_AW]) &&
                        (r_rx_wr[c_RX_AW-1:0] == r_rx_rd[c_RX_AW-1:0]);
    assign w_rx_push  = (r_state == c_ST_WRITE) && !w_rx_full;
    assign w_rx_pop   = !w_rx_empty && rx_ready;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr[c_RX_AW-1:0]] <= r_hold;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
        end else if (w_flush) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr <= r_rx_wr + c_RX_PTR_ONE;
            end
            if (w_rx_pop) begin
                r_rx_rd <= r_rx_rd + c_RX_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO: core pushes, link pops into the read-data register
    // ------------------------------------------------------------------
    logic [7:0]       r_tx_mem [TX_DEPTH];
    logic [c_TX_AW:0] r_tx_wr;
    logic [c_TX_AW:0] r_tx_rd;
    logic             w_tx_push;
    logic             w_tx_pop;

    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[c_TX_AW] != r_tx_rd[c_TX_AW]) &&
                        (r_tx_wr[c_TX_AW-1:0] == r_tx_rd[c_TX_AW-1:0]);
    assign w_tx_push  = tx_valid && !w_tx_full;
    assign w_tx_pop   = (r_state == c_ST_READ) && !w_tx_empty;
    assign w_tx_head  = r_tx_mem[r_tx_rd[c_TX_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[c_TX_AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else if (w_flush) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr <= r_tx_wr + c_TX_PTR_ONE;
            end
            if (w_tx_pop) begin
                r_tx_rd <= r_tx_rd + c_TX_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_unused;
    assign w_unused = &{1'b0, pio_in[28:8]};

    assign pio_out     = {(r_state == c_ST_ACK), !w_tx_empty, w_rx_full,
                          r_proto_err, 20'h00000, r_rd_reg};
    assign rx_data     = r_rx_mem[r_rx_rd[c_RX_AW-1:0]];
    assign rx_valid    = !w_rx_empty;
    assign tx_ready    = !w_tx_full;
    assign frame_start = r_frame_start;
    assign link_state  = r_state;

endmodule
`default_nettype wire
